ili9488_spi_slave: RTL and testbench

ILI9488_SPI_SLAVE -- requirements
Module: ili9488_spi_slave

---
 rtl/ili9488_spi_slave_if.sv | 12 +
 rtl/ili9488_spi_slave.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_ili9488_spi_slave.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ili9488_spi_slave_if.sv
// SPI pin bundle between a host controller and the ILI9488 slave model.
interface ili9488_spi_slave_if;
    logic Reset;
    logic CS;
    logic SCK;
    logic MOSI;
    logic D_C;
    logic MISO;

    modport master (output Reset, output CS, output SCK, output MOSI, output D_C, input MISO);
    modport slave  (input Reset, input CS, input SCK, input MOSI, input D_C, output MISO);
endinterface

// File: rtl/ili9488_spi_slave.sv
// ILI9488-style 4-wire SPI slave: command decode, CASET/PASET window, RAMWR
// RGB666 pixel stream with address generation, optional register readback.
// Optional feature macro: ILI9488_SLV_READ_EN (enables 0x0A/0x0C/0xDA reads on MISO).
module ili9488_spi_slave #(
    parameter int unsigned MAX_X   = 319,
    parameter int unsigned MAX_Y   = 479,
    parameter logic [7:0]  ID1_VAL = 8'h54
) (
    input  logic               clk,
    input  logic               rst,
    ili9488_spi_slave_if.slave spi,
    output logic               cmd_valid,
    output logic [7:0]         cmd_byte,
    output logic               pix_valid,
    output logic [17:0]        pix_data,
    output logic [8:0]         pix_x,
    output logic [8:0]         pix_y,
    output logic               disp_on,
    output logic               sleep_out
);
    localparam int unsigned   AW         = 9;
    localparam logic [AW-1:0] MAX_X_C    = AW'(MAX_X);
    localparam logic [AW-1:0] MAX_Y_C    = AW'(MAX_Y);
    localparam logic [7:0]    COLMOD_RST = 8'h66;

    localparam logic [7:0] OP_SWRESET = 8'h01;
    localparam logic [7:0] OP_SLPIN   = 8'h10;
    localparam logic [7:0] OP_SLPOUT  = 8'h11;
    localparam logic [7:0] OP_DISPOFF = 8'h28;
    localparam logic [7:0] OP_DISPON  = 8'h29;
    localparam logic [7:0] OP_CASET   = 8'h2A;
    localparam logic [7:0] OP_PASET   = 8'h2B;
    localparam logic [7:0] OP_RAMWR   = 8'h2C;
    localparam logic [7:0] OP_COLMOD  = 8'h3A;
`ifdef ILI9488_SLV_READ_EN
    localparam logic [7:0] OP_RDDPM   = 8'h0A;
    localparam logic [7:0] OP_RDCOLM  = 8'h0C;
    localparam logic [7:0] OP_RDID1   = 8'hDA;
`endif

    typedef enum logic [1:0] {
        ST_CMD   = 2'd0,
        ST_PARAM = 2'd1,
`ifdef ILI9488_SLV_READ_EN
        ST_PIXEL = 2'd2,
        ST_READ  = 2'd3
`else
        ST_PIXEL = 2'd2
`endif
    } state_e;

    typedef enum logic [1:0] {
        CTX_CASET  = 2'd0,
        CTX_PASET  = 2'd1,
        CTX_COLMOD = 2'd2
    } ctx_e;

    // ---------------- pin synchronizers ----------------
    logic [1:0] cs_s_q, cs_s_d;
    logic [2:0] sck_s_q, sck_s_d;
    logic [1:0] mosi_s_q, mosi_s_d;
    logic [1:0] dc_s_q, dc_s_d;
    logic [1:0] rstp_s_q, rstp_s_d;

    // Shift each pin through two flops; SCK gets a third for edge detection.
    always_comb begin
        cs_s_d   = {cs_s_q[0], spi.CS};
        sck_s_d  = {sck_s_q[1:0], spi.SCK};
        mosi_s_d = {mosi_s_q[0], spi.MOSI};
        dc_s_d   = {dc_s_q[0], spi.D_C};
        rstp_s_d = {rstp_s_q[0], spi.Reset};
    end

    // Synchronizer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_s_q   <= 2'b11;
            sck_s_q  <= '0;
            mosi_s_q <= '0;
            dc_s_q   <= '0;
            rstp_s_q <= '0;
        end else begin
            cs_s_q   <= cs_s_d;
            sck_s_q  <= sck_s_d;
            mosi_s_q <= mosi_s_d;
            dc_s_q   <= dc_s_d;
            rstp_s_q <= rstp_s_d;
        end
    end

    logic sck_rise_c, sck_fall_c, cs_act_c, soft_rst_c;
    assign sck_rise_c = sck_s_q[1] & ~sck_s_q[2];
    assign sck_fall_c = ~sck_s_q[1] & sck_s_q[2];
    assign cs_act_c   = ~cs_s_q[1];

    // ---------------- byte assembly ----------------
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic       byte_rdy_q, byte_rdy_d;
    logic [7:0] byte_q, byte_d;
    logic       byte_dc_q, byte_dc_d;

    assign soft_rst_c = ~rstp_s_q[1] | (byte_rdy_q & ~byte_dc_q & (byte_q == OP_SWRESET));

    // Collect MOSI bits on rising SCK; CS high throws away a partial byte.
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_rdy_d = 1'b0;
        byte_d     = byte_q;
        byte_dc_d  = byte_dc_q;
        if (soft_rst_c || !cs_act_c) begin
            bit_cnt_d = '0;
        end else if (sck_rise_c) begin
            shift_d   = {shift_q[5:0], mosi_s_q[1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                byte_rdy_d = 1'b1;
                byte_d     = {shift_q, mosi_s_q[1]};
                byte_dc_d  = dc_s_q[1];
            end
        end
    end

    // Byte assembly registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            byte_rdy_q <= 1'b0;
            byte_q     <= '0;
            byte_dc_q  <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            byte_rdy_q <= byte_rdy_d;
            byte_q     <= byte_d;
            byte_dc_q  <= byte_dc_d;
        end
    end

    // ---------------- command / pixel engine ----------------
    state_e        state_q, state_d;
    ctx_e          ctx_q, ctx_d;
    logic [1:0]    prm_cnt_q, prm_cnt_d;
    logic [AW-1:0] ps_q, ps_d;
    logic          pe_hi_q, pe_hi_d;
    logic [AW-1:0] sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
    logic [7:0]    colmod_q, colmod_d;
    logic [AW-1:0] x_q, x_d, y_q, y_d;
    logic [1:0]    pb_cnt_q, pb_cnt_d;
    logic [5:0]    r_q, r_d, g_q, g_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic [7:0]    cmd_byte_q, cmd_byte_d;
    logic          pix_valid_q, pix_valid_d;
    logic [17:0]   pix_data_q, pix_data_d;
    logic [AW-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic          disp_on_q, disp_on_d;
    logic          sleep_out_q, sleep_out_d;
`ifdef ILI9488_SLV_READ_EN
    logic [7:0]    rd_shift_q, rd_shift_d;
    logic [3:0]    rd_cnt_q, rd_cnt_d;
    logic          miso_q, miso_d;
`endif

    // End address of the window being programmed, clamped to the panel limit.
    logic [AW-1:0] lim_c, raw_e_c, win_e_c;
    assign lim_c   = (ctx_q == CTX_PASET) ? MAX_Y_C : MAX_X_C;
    assign raw_e_c = {pe_hi_q, byte_q};
    assign win_e_c = (raw_e_c > lim_c) ? lim_c : raw_e_c;

    // Next-state and output logic for the command/parameter/pixel/read FSM.
    always_comb begin
        state_d     = state_q;
        ctx_d       = ctx_q;
        prm_cnt_d   = prm_cnt_q;
        ps_d        = ps_q;
        pe_hi_d     = pe_hi_q;
        sc_d        = sc_q;
        ec_d        = ec_q;
        sp_d        = sp_q;
        ep_d        = ep_q;
        colmod_d    = colmod_q;
        x_d         = x_q;
        y_d         = y_q;
        pb_cnt_d    = pb_cnt_q;
        r_d         = r_q;
        g_d         = g_q;
        cmd_valid_d = 1'b0;
        cmd_byte_d  = cmd_byte_q;
        pix_valid_d = 1'b0;
        pix_data_d  = pix_data_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        disp_on_d   = disp_on_q;
        sleep_out_d = sleep_out_q;
`ifdef ILI9488_SLV_READ_EN
        rd_shift_d  = rd_shift_q;
        rd_cnt_d    = rd_cnt_q;
        miso_d      = miso_q;
`endif
        if (soft_rst_c) begin
            state_d     = ST_CMD;
            ctx_d       = CTX_CASET;
            prm_cnt_d   = '0;
            ps_d        = '0;
            pe_hi_d     = 1'b0;
            sc_d        = '0;
            ec_d        = MAX_X_C;
            sp_d        = '0;
            ep_d        = MAX_Y_C;
            colmod_d    = COLMOD_RST;
            x_d         = '0;
            y_d         = '0;
            pb_cnt_d    = '0;
            r_d         = '0;
            g_d         = '0;
            cmd_byte_d  = '0;
            pix_data_d  = '0;
            pix_x_d     = '0;
            pix_y_d     = '0;
            disp_on_d   = 1'b0;
            sleep_out_d = 1'b0;
`ifdef ILI9488_SLV_READ_EN
            rd_shift_d  = '0;
            rd_cnt_d    = '0;
`endif
        end else begin
`ifdef ILI9488_SLV_READ_EN
            // Response shifts out on falling SCK; the first fall is the command's 8th.
            if (state_q == ST_READ) begin
                if (!cs_act_c) begin
                    state_d = ST_CMD;
                end else if (sck_fall_c) begin
                    if (rd_cnt_q == 4'd8) begin
                        state_d = ST_CMD;
                    end else begin
                        miso_d     = rd_shift_q[7];
                        rd_shift_d = {rd_shift_q[6:0], 1'b0};
                        rd_cnt_d   = rd_cnt_q + 4'd1;
                    end
                end
            end
`endif
            if (byte_rdy_q) begin
                if (!byte_dc_q) begin
                    cmd_valid_d = 1'b1;
                    cmd_byte_d  = byte_q;
                    state_d     = ST_CMD;
                    prm_cnt_d   = '0;
                    pb_cnt_d    = '0;
                    case (byte_q)
                        OP_SLPIN:   sleep_out_d = 1'b0;
                        OP_SLPOUT:  sleep_out_d = 1'b1;
                        OP_DISPOFF: disp_on_d   = 1'b0;
                        OP_DISPON:  disp_on_d   = 1'b1;
                        OP_CASET: begin
                            state_d = ST_PARAM;
                            ctx_d   = CTX_CASET;
                        end
                        OP_PASET: begin
                            state_d = ST_PARAM;
                            ctx_d   = CTX_PASET;
                        end
                        OP_COLMOD: begin
                            state_d = ST_PARAM;
                            ctx_d   = CTX_COLMOD;
                        end
                        OP_RAMWR: begin
                            state_d = ST_PIXEL;
                            x_d     = sc_q;
                            y_d     = sp_q;
                        end
`ifdef ILI9488_SLV_READ_EN
                        OP_RDDPM: begin
                            state_d    = ST_READ;
                            rd_shift_d = {3'b000, sleep_out_q, 1'b0, disp_on_q, 2'b00};
                            rd_cnt_d   = '0;
                        end
                        OP_RDCOLM: begin
                            state_d    = ST_READ;
                            rd_shift_d = colmod_q;
                            rd_cnt_d   = '0;
                        end
                        OP_RDID1: begin
                            state_d    = ST_READ;
                            rd_shift_d = ID1_VAL;
                            rd_cnt_d   = '0;
                        end
`endif
                        default: ;
                    endcase
                end else begin
                    case (state_q)
                        ST_PARAM: begin
                            prm_cnt_d = prm_cnt_q + 2'd1;
                            if (ctx_q == CTX_COLMOD) begin
                                colmod_d = byte_q;
                                state_d  = ST_CMD;
                            end else begin
                                case (prm_cnt_q)
                                    2'd0: ps_d[8]   = byte_q[0];
                                    2'd1: ps_d[7:0] = byte_q;
                                    2'd2: pe_hi_d   = byte_q[0];
                                    default: begin
                                        state_d = ST_CMD;
                                        if (ps_q <= win_e_c) begin
                                            if (ctx_q == CTX_PASET) begin
                                                sp_d = ps_q;
                                                ep_d = win_e_c;
                                            end else begin
                                                sc_d = ps_q;
                                                ec_d = win_e_c;
                                            end
                                        end
                                    end
                                endcase
                            end
                        end
                        ST_PIXEL: begin
                            case (pb_cnt_q)
                                2'd0: begin
                                    r_d      = byte_q[7:2];
                                    pb_cnt_d = 2'd1;
                                end
                                2'd1: begin
                                    g_d      = byte_q[7:2];
                                    pb_cnt_d = 2'd2;
                                end
                                default: begin
                                    pb_cnt_d    = '0;
                                    pix_valid_d = 1'b1;
                                    pix_data_d  = {r_q, g_q, byte_q[7:2]};
                                    pix_x_d     = x_q;
                                    pix_y_d     = y_q;
                                    if (x_q == ec_q) begin
                                        x_d = sc_q;
                                        y_d = (y_q == ep_q) ? sp_q : y_q + 9'd1;
                                    end else begin
                                        x_d = x_q + 9'd1;
                                    end
                                end
                            endcase
                        end
                        default: ;
                    endcase
                end
            end
        end
`ifdef ILI9488_SLV_READ_EN
        if (state_d != ST_READ) begin
            miso_d = 1'b0;
        end
`endif
    end

    // Engine state and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_CMD;
            ctx_q       <= CTX_CASET;
            prm_cnt_q   <= '0;
            ps_q        <= '0;
            pe_hi_q     <= 1'b0;
            sc_q        <= '0;
            ec_q        <= MAX_X_C;
            sp_q        <= '0;
            ep_q        <= MAX_Y_C;
            colmod_q    <= COLMOD_RST;
            x_q         <= '0;
            y_q         <= '0;
            pb_cnt_q    <= '0;
            r_q         <= '0;
            g_q         <= '0;
            cmd_valid_q <= 1'b0;
            cmd_byte_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            disp_on_q   <= 1'b0;
            sleep_out_q <= 1'b0;
`ifdef ILI9488_SLV_READ_EN
            rd_shift_q  <= '0;
            rd_cnt_q    <= '0;
            miso_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ctx_q       <= ctx_d;
            prm_cnt_q   <= prm_cnt_d;
            ps_q        <= ps_d;
            pe_hi_q     <= pe_hi_d;
            sc_q        <= sc_d;
            ec_q        <= ec_d;
            sp_q        <= sp_d;
            ep_q        <= ep_d;
            colmod_q    <= colmod_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pb_cnt_q    <= pb_cnt_d;
            r_q         <= r_d;
            g_q         <= g_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_byte_q  <= cmd_byte_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            disp_on_q   <= disp_on_d;
            sleep_out_q <= sleep_out_d;
`ifdef ILI9488_SLV_READ_EN
            rd_shift_q  <= rd_shift_d;
            rd_cnt_q    <= rd_cnt_d;
            miso_q      <= miso_d;
`endif
        end
    end

`ifdef ILI9488_SLV_READ_EN
    assign spi.MISO = miso_q;
`else
    // Readback hardware is absent; keep its configuration inputs referenced.
    logic unused_rd_c;
    assign unused_rd_c = ^{ID1_VAL, colmod_q, sck_fall_c};
    assign spi.MISO    = 1'b0;
`endif

    assign cmd_valid = cmd_valid_q;
    assign cmd_byte  = cmd_byte_q;
    assign pix_valid = pix_valid_q;
    assign pix_data  = pix_data_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign disp_on   = disp_on_q;
    assign sleep_out = sleep_out_q;
endmodule

// File: tb/tb_ili9488_spi_slave.sv
// Bench for ili9488_spi_slave: byte-table stimulus with a cmd/pixel scoreboard,
// plus hand sequences for CS aborts, resets and MISO readback.
module tb_ili9488_spi_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [7:0]  cmd_byte;
    logic        pix_valid;
    logic [17:0] pix_data;
    logic [8:0]  pix_x;
    logic [8:0]  pix_y;
    logic        disp_on;
    logic        sleep_out;

    ili9488_spi_slave_if spi ();

    ili9488_spi_slave dut (
        .clk       (clk),
        .rst       (rst),
        .spi       (spi),
        .cmd_valid (cmd_valid),
        .cmd_byte  (cmd_byte),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .disp_on   (disp_on),
        .sleep_out (sleep_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  cmd_q[$];
    logic [35:0] pix_q[$];

    typedef struct {
        logic [7:0]  b;
        logic        dc;
        logic        fchk;
        logic        disp;
        logic        slp;
        logic        pchk;
        logic [35:0] pix;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [35:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    // Scoreboard: every cmd/pixel pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst) begin
            if (cmd_valid) begin
                if (cmd_q.size() == 0) unexpected("cmd_unexpected", {28'd0, cmd_byte});
                else chk("cmd_byte", {28'd0, cmd_byte}, {28'd0, cmd_q.pop_front()});
            end
            if (pix_valid) begin
                if (pix_q.size() == 0) unexpected("pix_unexpected", {pix_x, pix_y, pix_data});
                else chk("pixel", {pix_x, pix_y, pix_data}, pix_q.pop_front());
            end
        end
    end

    function automatic void vc(input logic [7:0] b);
        tbl.push_back('{b: b, dc: 1'b0, fchk: 1'b0, disp: 1'b0, slp: 1'b0, pchk: 1'b0, pix: '0});
    endfunction
    function automatic void vcf(input logic [7:0] b, input logic disp, input logic slp);
        tbl.push_back('{b: b, dc: 1'b0, fchk: 1'b1, disp: disp, slp: slp, pchk: 1'b0, pix: '0});
    endfunction
    function automatic void vd(input logic [7:0] b);
        tbl.push_back('{b: b, dc: 1'b1, fchk: 1'b0, disp: 1'b0, slp: 1'b0, pchk: 1'b0, pix: '0});
    endfunction
    function automatic void vp(input logic [7:0] b, input logic [8:0] x, input logic [8:0] y,
                               input logic [17:0] d);
        tbl.push_back('{b: b, dc: 1'b1, fchk: 1'b0, disp: 1'b0, slp: 1'b0, pchk: 1'b1, pix: {x, y, d}});
    endfunction

    task automatic sck_bit(input logic b, input logic dc);
        spi.MOSI = b;
        spi.D_C  = dc;
        #40;
        spi.SCK = 1'b1;
        #80;
        spi.SCK = 1'b0;
        #40;
    endtask

    task automatic send_bits(input logic [7:0] b, input logic dc, input int n);
        for (int i = 7; i > 7 - n; i--) sck_bit(b[i], dc);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        cmd_q.push_back(b);
        send_bits(b, 1'b0, 8);
    endtask

    task automatic send_dat(input logic [7:0] b);
        send_bits(b, 1'b1, 8);
    endtask

    task automatic cs_bounce();
        spi.CS = 1'b1;
        #100;
        spi.CS = 1'b0;
        #50;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_cmd_valid"}, {35'd0, cmd_valid}, 36'd0);
        chk({tag, "_cmd_byte"},  {28'd0, cmd_byte},  36'd0);
        chk({tag, "_pix_valid"}, {35'd0, pix_valid}, 36'd0);
        chk({tag, "_pix_data"},  {18'd0, pix_data},  36'd0);
        chk({tag, "_pix_xy"},    {18'd0, pix_x, pix_y}, 36'd0);
        chk({tag, "_disp_on"},   {35'd0, disp_on},   36'd0);
        chk({tag, "_sleep_out"}, {35'd0, sleep_out}, 36'd0);
        chk({tag, "_miso"},      {35'd0, spi.MISO},  36'd0);
    endtask

    logic [7:0] rexp;

    initial begin
        rst       = 1'b0;
        spi.Reset = 1'b1;
        spi.CS    = 1'b1;
        spi.SCK   = 1'b0;
        spi.MOSI  = 1'b0;
        spi.D_C   = 1'b0;

        // Table: flags, window setup, pixel streams, clamping, ignored params.
        vcf(8'h29, 1'b1, 1'b0);
        vcf(8'h11, 1'b1, 1'b1);
        vc(8'h2A); vd(8'h00); vd(8'h0A); vd(8'h00); vd(8'h0B);
        vc(8'h2B); vd(8'h00); vd(8'h14); vd(8'h00); vd(8'h14);
        vc(8'h2C);
        vd(8'hFC); vd(8'h00); vp(8'h00, 9'd10, 9'd20, 18'h3F000);
        vd(8'h00); vd(8'hFC); vp(8'h00, 9'd11, 9'd20, 18'h00FC0);
        vd(8'hFC); vd(8'hFC); vp(8'hFC, 9'd10, 9'd20, 18'h3FFFF);
        vcf(8'h28, 1'b0, 1'b1);
        vc(8'h2A); vd(8'h01); vd(8'h3E); vd(8'h01); vd(8'hFF);
        vc(8'h2B); vd(8'h01); vd(8'hDE); vd(8'h01); vd(8'hDF);
        vc(8'h2C);
        vd(8'h04); vd(8'h08); vp(8'h0C, 9'd318, 9'd478, 18'h01083);
        vd(8'hFC); vd(8'h04); vp(8'h80, 9'd319, 9'd478, 18'h3F060);
        vd(8'h00); vd(8'h00); vp(8'h04, 9'd318, 9'd479, 18'h00001);
        vd(8'h80); vd(8'h80); vp(8'h80, 9'd319, 9'd479, 18'h20820);
        vd(8'h03); vd(8'h03); vp(8'h03, 9'd318, 9'd478, 18'h00000);
        vc(8'h2A); vd(8'h00); vd(8'h20); vd(8'h00); vd(8'h10); vd(8'h55);
        vc(8'h2C);
        vd(8'h04); vd(8'h08); vp(8'h0C, 9'd318, 9'd478, 18'h01083);
        vd(8'hFC); vd(8'hFC);
        vc(8'h2C);
        vd(8'h00); vd(8'h00); vp(8'h04, 9'd318, 9'd478, 18'h00001);
        vc(8'h3A); vd(8'h55); vd(8'h77); vd(8'h99);
        vcf(8'h10, 1'b0, 1'b0);
        vcf(8'h29, 1'b1, 1'b0);

        #33;
        chk_zero_outputs("in_rst");
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        chk_zero_outputs("post_rst");

        spi.CS = 1'b0;
        #50;
        foreach (tbl[i]) begin
            if (!tbl[i].dc && tbl[i].b != 8'h01) cmd_q.push_back(tbl[i].b);
            if (tbl[i].pchk) pix_q.push_back(tbl[i].pix);
            send_bits(tbl[i].b, tbl[i].dc, 8);
            if (tbl[i].fchk) begin
                chk($sformatf("v%0d_disp_on", i),   {35'd0, disp_on},   {35'd0, tbl[i].disp});
                chk($sformatf("v%0d_sleep_out", i), {35'd0, sleep_out}, {35'd0, tbl[i].slp});
            end
        end

        // Partial byte cut by CS high is dropped; only the full 0x28 decodes.
        send_bits(8'h28, 1'b0, 5);
        cs_bounce();
        send_cmd(8'h28);
        #100;
        chk("partial_disp_on", {35'd0, disp_on}, 36'd0);
        chk("partial_cmd_byte", {28'd0, cmd_byte}, 36'h28);

        // Pixel byte count and RAMWR context survive a CS high gap.
        send_cmd(8'h2C);
        send_dat(8'hFC);
        cs_bounce();
        send_dat(8'h04);
        pix_q.push_back({9'd318, 9'd478, 18'h3F060});
        send_dat(8'h80);

        // Panel Reset pin and software reset 0x01 restore defaults.
        send_cmd(8'h29);
        send_cmd(8'h11);
        spi.Reset = 1'b0;
        #100;
        spi.Reset = 1'b1;
        #100;
        chk("rstpin_disp_on", {35'd0, disp_on}, 36'd0);
        chk("rstpin_sleep_out", {35'd0, sleep_out}, 36'd0);
        chk("rstpin_cmd_byte", {28'd0, cmd_byte}, 36'd0);
        send_cmd(8'h29);
        send_bits(8'h01, 1'b0, 8);
        #100;
        chk("swrst_disp_on", {35'd0, disp_on}, 36'd0);
        chk("swrst_cmd_byte", {28'd0, cmd_byte}, 36'd0);
        send_cmd(8'h2C);
        send_dat(8'h04); send_dat(8'h08);
        pix_q.push_back({9'd0, 9'd0, 18'h01083});
        send_dat(8'h0C);
        send_dat(8'h80); send_dat(8'h80);
        pix_q.push_back({9'd1, 9'd0, 18'h20820});
        send_dat(8'h80);

        // Status readback over MISO.
        send_cmd(8'h11);
        send_cmd(8'h29);
        send_cmd(8'h0A);
`ifdef ILI9488_SLV_READ_EN
        rexp = 8'h14;
`else
        rexp = 8'h00;
`endif
        for (int i = 0; i < 8; i++) begin
            spi.MOSI = 1'b0;
            spi.D_C  = 1'b1;
            #40;
            chk($sformatf("miso_bit%0d", 7 - i), {35'd0, spi.MISO}, {35'd0, rexp[7 - i]});
            spi.SCK = 1'b1;
            #80;
            spi.SCK = 1'b0;
            #40;
        end
        #100;
        chk("miso_after_read", {35'd0, spi.MISO}, 36'd0);
        send_cmd(8'h28);
        #50;
        chk("post_read_disp_on", {35'd0, disp_on}, 36'd0);

        // Async reset in the middle of a RAMWR stream.
        send_cmd(8'h29);
        send_cmd(8'h2A);
        send_dat(8'h00); send_dat(8'h0A); send_dat(8'h00); send_dat(8'h0B);
        send_cmd(8'h2C);
        send_dat(8'hFC); send_dat(8'h00);
        @(negedge clk);
        rst = 1'b0;
        #20;
        chk_zero_outputs("mid_rst");
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        send_dat(8'h00); send_dat(8'hFC); send_dat(8'h00);
        send_dat(8'hFC); send_dat(8'hFC); send_dat(8'hFC);
        chk("mid_rst_disp_on", {35'd0, disp_on}, 36'd0);
        send_cmd(8'h2C);
        send_dat(8'h00); send_dat(8'hFC);
        pix_q.push_back({9'd0, 9'd0, 18'h00FC0});
        send_dat(8'h00);

        #300;
        chk("cmd_queue_drained", 36'(cmd_q.size()), 36'd0);
        chk("pix_queue_drained", 36'(pix_q.size()), 36'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
